// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC mux and circular return-address stack.
// Supports sequential, relative-branch, absolute-jump and return modes.
module pc_unit #(
  parameter int WIDTH        = 8,
  parameter int RESET_VECTOR = 10,
  parameter int STEP         = 1,
  parameter int RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EscPC,
  input  logic [1:0]       pc_sel,
  input  logic             call,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] SaidaPC,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] INC = WIDTH'(STEP);
  localparam logic [CW-1:0]    CAP = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_br;

  logic is_seq;
  logic is_br;
  logic is_jmp;
  logic is_ret;
  logic do_push;
  logic do_pop;
  logic do_unf;

  assign pc_seq  = SaidaPC + INC;
  assign pc_br   = SaidaPC + offset;
  assign top_idx = wptr_q - PW'(1);

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CAP);
  assign ras_top   = ras_empty ? '0 : ras_q[top_idx];

  assign is_seq = (pc_sel == 2'b00);
  assign is_br  = (pc_sel == 2'b01);
  assign is_jmp = (pc_sel == 2'b10);
  assign is_ret = (pc_sel == 2'b11);

  // call only means something alongside a taken branch or jump
  assign do_push = call & (is_br | is_jmp);
  assign do_pop  = is_ret & ~ras_empty;
  assign do_unf  = is_ret & ras_empty;

  always_comb begin
    pc_next = pc_seq;
    unique case (1'b1)
      is_seq: pc_next = pc_seq;
      is_br:  pc_next = pc_br;
      is_jmp: pc_next = target;
      is_ret: pc_next = do_pop ? ras_top : pc_seq;
      default: pc_next = pc_seq;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      SaidaPC <= RV;
      wptr_q  <= '0;
      cnt_q   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= '0;
    end else if (EscPC) begin
      SaidaPC <= pc_next;
      // when full the write pointer already sits on the oldest entry
      if (do_push) begin
        ras_q[wptr_q] <= pc_seq;
        wptr_q        <= wptr_q + PW'(1);
        if (ras_full)
          ras_ovf <= 1'b1;
        else
          cnt_q <= cnt_q + CW'(1);
      end
      if (do_pop) begin
        wptr_q <= top_idx;
        cnt_q  <= cnt_q - CW'(1);
      end
      if (do_unf)
        ras_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queue-based scoreboard.
// Reference stack is a bounded LIFO queue that drops its oldest entry.
module tb_pc_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       EscPC;
  logic [1:0] pc_sel;
  logic       call;
  logic [7:0] target;
  logic [7:0] offset;
  logic [7:0] SaidaPC;
  logic [7:0] pc_next;
  logic [7:0] ras_top;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_ovf;
  logic       ras_unf;

  pc_unit #(
    .WIDTH(8),
    .RESET_VECTOR(10),
    .STEP(1),
    .RAS_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .EscPC(EscPC),
    .pc_sel(pc_sel),
    .call(call),
    .target(target),
    .offset(offset),
    .SaidaPC(SaidaPC),
    .pc_next(pc_next),
    .ras_top(ras_top),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] top;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] m_stk[$];
  logic [7:0] m_pc  = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic cl,
                      input logic [1:0] sel, input logic [7:0] tgt,
                      input logic [7:0] off);
    exp_t       e;
    logic [7:0] seq;
    logic [7:0] npc;
    reset  = rst;
    EscPC  = en;
    call   = cl;
    pc_sel = sel;
    target = tgt;
    offset = off;
    #1;
    seq = m_pc + 8'd1;
    case (sel)
      2'b00: npc = seq;
      2'b01: npc = m_pc + off;
      2'b10: npc = tgt;
      default: npc = (m_stk.size() != 0) ? m_stk[$] : seq;
    endcase
    chk("pc_next", pc_next, npc);
    if (rst) begin
      m_pc  = 8'h0A;
      m_stk = {};
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      if (sel == 2'b11) begin
        if (m_stk.size() != 0) void'(m_stk.pop_back());
        else m_unf = 1'b1;
      end
      if (cl && (sel == 2'b01 || sel == 2'b10)) begin
        if (m_stk.size() == 4) begin
          m_ovf = 1'b1;
          void'(m_stk.pop_front());
        end
        m_stk.push_back(seq);
      end
      m_pc = npc;
    end
    e.pc    = m_pc;
    e.top   = (m_stk.size() != 0) ? m_stk[$] : 8'h00;
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == 4);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    chk("pc",    SaidaPC,          e.pc);
    chk("top",   ras_top,          e.top);
    chk("empty", {7'd0, ras_empty}, {7'd0, e.empty});
    chk("full",  {7'd0, ras_full},  {7'd0, e.full});
    chk("ovf",   {7'd0, ras_ovf},   {7'd0, e.ovf});
    chk("unf",   {7'd0, ras_unf},   {7'd0, e.unf});
  endtask

  task automatic seq_s();
    step(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic jmp(input logic [7:0] t, input logic cl);
    step(1'b0, 1'b1, cl, 2'b10, t, 8'h00);
  endtask

  task automatic ret();
    step(1'b0, 1'b1, 1'b0, 2'b11, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] hold_pc;
    logic [7:0] hold_top;
    reset  = 1'b1;
    EscPC  = 1'b1;
    pc_sel = 2'b00;
    call   = 1'b0;
    target = 8'h00;
    offset = 8'h00;

    step(1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    chk("reset_pc", SaidaPC, 8'h0A);
    seq_s();
    chk("seq1", SaidaPC, 8'h0B);
    seq_s();
    chk("seq2", SaidaPC, 8'h0C);

    jmp(8'h30, 1'b1);
    hold_pc  = SaidaPC;
    hold_top = ras_top;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'($urandom), 2'($urandom),
           8'($urandom), 8'($urandom));
    chk("hold_pc",  SaidaPC, hold_pc);
    chk("hold_top", ras_top, hold_top);
    ret();

    jmp(8'hFF, 1'b0);
    seq_s();
    chk("wrap", SaidaPC, 8'h00);
    jmp(8'h05, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'hFE);
    chk("neg_branch", SaidaPC, 8'h03);

    jmp(8'h10, 1'b0);
    jmp(8'h40, 1'b1);
    chk("call_pc",  SaidaPC, 8'h40);
    chk("call_top", ras_top, 8'h11);
    ret();
    chk("ret_pc", SaidaPC, 8'h11);
    chk("ret_empty", {7'd0, ras_empty}, 8'h01);

    jmp(8'h50, 1'b0);
    jmp(8'h60, 1'b1);
    jmp(8'h70, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'b01, 8'h00, 8'h10);
    jmp(8'h90, 1'b1);
    jmp(8'hA0, 1'b1);
    chk("ovf_flag",  {7'd0, ras_ovf},  8'h01);
    chk("full_flag", {7'd0, ras_full}, 8'h01);
    ret();
    chk("lifo1", SaidaPC, 8'h91);
    ret();
    chk("lifo2", SaidaPC, 8'h81);
    ret();
    chk("lifo3", SaidaPC, 8'h71);
    ret();
    chk("lifo4", SaidaPC, 8'h61);

    step(1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    jmp(8'h20, 1'b0);
    ret();
    chk("unf_pc",   SaidaPC, 8'h21);
    chk("unf_flag", {7'd0, ras_unf}, 8'h01);
    step(1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 8'h00);
    seq_s();
    chk("unf_sticky", {7'd0, ras_unf}, 8'h01);

    jmp(8'hC0, 1'b1);
    jmp(8'hD0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 2'b10, 8'hE0, 8'h00);
    chk("mid_reset_pc", SaidaPC, 8'h0A);
    chk("mid_reset_empty", {7'd0, ras_empty}, 8'h01);

    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 4) != 0),
           1'($urandom), 2'($urandom),
           8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
